// File: rtl/boreal_cursor_event_fifo.sv
// Cursor integrator and click edge detector feeding an event FIFO with a valid/ready host port.
// Optional build macro CURSOR_ACCEL_EN doubles large velocity steps before clipping.
module boreal_cursor_event_fifo #(
    parameter int POS_W      = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int GAIN_SHIFT = 10,
    parameter int ACCEL_THR  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid,
    input  logic signed [23:0]  ux,
    input  logic signed [23:0]  uy,
    input  logic                click,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [1:0]          evt_type,
    output logic [POS_W-1:0]    evt_x,
    output logic [POS_W-1:0]    evt_y,
    output logic                overflow,
    input  logic [2:0]          reg_addr,
    input  logic [15:0]         reg_din,
    input  logic                reg_we
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ENT_W  = 2 + 2 * POS_W;
    localparam int STEP_W = 25;
    localparam int SUM_W  = POS_W + 2;

    localparam logic [1:0] T_MOVE    = 2'd0;
    localparam logic [1:0] T_PRESS   = 2'd1;
    localparam logic [1:0] T_RELEASE = 2'd2;

    localparam logic signed [STEP_W-1:0] STEP_LIM = STEP_W'((1 << POS_W) - 1);
    localparam logic signed [SUM_W-1:0]  SUM_LIM  = SUM_W'((1 << POS_W) - 1);
    localparam logic [PTR_W:0]           FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [3:0]               GAIN_RST = 4'(GAIN_SHIFT);

    function automatic logic signed [SUM_W-1:0] clip_step(input logic signed [STEP_W-1:0] s);
        if (s > STEP_LIM)
            return SUM_LIM;
        else if (s < -STEP_LIM)
            return -SUM_LIM;
        else
            return s[SUM_W-1:0];
    endfunction

    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [SUM_W-1:0] v,
                                                   input logic [POS_W-1:0]        vmax);
        if (v[SUM_W-1])
            return '0;
        else if (v > $signed({2'b00, vmax}))
            return vmax;
        else
            return v[POS_W-1:0];
    endfunction

`ifdef CURSOR_ACCEL_EN
    localparam logic signed [STEP_W-1:0] ACCEL_LIM = STEP_W'(ACCEL_THR);

    function automatic logic signed [STEP_W-1:0] shape_step(input logic signed [STEP_W-1:0] s);
        if (s > ACCEL_LIM || s < -ACCEL_LIM)
            return s <<< 1;
        return s;
    endfunction
`else
    function automatic logic signed [STEP_W-1:0] shape_step(input logic signed [STEP_W-1:0] s);
        return s;
    endfunction

    logic unused_thr;
    assign unused_thr = ^32'(ACCEL_THR);
`endif

    logic unused_din;
    assign unused_din = ^reg_din[15:POS_W];

    logic [3:0]              gain;
    logic [POS_W-1:0]        x_max, y_max;
    logic [POS_W-1:0]        pos_x, pos_y;
    logic                    move_pend, btn_pend, click_d;
    logic [1:0]              btn_type;
    logic [ENT_W-1:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [PTR_W:0]          count;

    logic signed [23:0]      ux_sh, uy_sh;
    logic signed [SUM_W-1:0] step_x_p0, step_y_p0;
    logic                    vld_p0;
    logic [POS_W-1:0]        nx_p1, ny_p1;

    assign ux_sh = ux >>> gain;
    assign uy_sh = uy >>> gain;

    // Stage p0: shifted, shaped and clipped step; a valid alongside a config write is dropped
    always_ff @(posedge clk) begin
        step_x_p0 <= clip_step(shape_step(STEP_W'(ux_sh)));
        step_y_p0 <= clip_step(shape_step(STEP_W'(uy_sh)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= valid & ~reg_we;
    end

    // Stage p1: integrate and clamp into the window
    assign nx_p1 = clamp_pos($signed({2'b00, pos_x}) + step_x_p0, x_max);
    assign ny_p1 = clamp_pos($signed({2'b00, pos_y}) + step_y_p0, y_max);

    logic recentre, moved, move_set;
    logic edge_seen, btn_accept, btn_drop;
    logic pop, can_push, push_btn, push_move, push;
    logic [1:0] push_type;

    assign recentre   = reg_we && (reg_addr == 3'd3);
    assign moved      = vld_p0 && !recentre && ((nx_p1 != pos_x) || (ny_p1 != pos_y));
    assign move_set   = recentre | moved;

    assign pop        = evt_valid & evt_ready;
    assign can_push   = (count != FULL_CNT) | pop;
    assign push_btn   = btn_pend & can_push;
    assign push_move  = move_pend & ~btn_pend & can_push;
    assign push       = push_btn | push_move;
    assign push_type  = push_btn ? btn_type : T_MOVE;

    // A slot freed by this cycle's button push can take a new edge immediately
    assign edge_seen  = click ^ click_d;
    assign btn_accept = edge_seen & (~btn_pend | push_btn);
    assign btn_drop   = edge_seen & btn_pend & ~push_btn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain      <= GAIN_RST;
            x_max     <= '1;
            y_max     <= '1;
            pos_x     <= '0;
            pos_y     <= '0;
            move_pend <= 1'b0;
            btn_pend  <= 1'b0;
            btn_type  <= T_MOVE;
            click_d   <= 1'b0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            click_d <= click;

            if (reg_we) begin
                case (reg_addr)
                    3'd0:    gain <= reg_din[3:0];
                    3'd1:    x_max <= reg_din[POS_W-1:0];
                    3'd2:    y_max <= reg_din[POS_W-1:0];
                    3'd3: begin
                        pos_x <= x_max >> 1;
                        pos_y <= y_max >> 1;
                    end
                    3'd4:    overflow <= 1'b0;
                    default: ;
                endcase
            end

            if (moved) begin
                pos_x <= nx_p1;
                pos_y <= ny_p1;
            end

            move_pend <= move_set | (move_pend & ~push_move);
            btn_pend  <= btn_accept | (btn_pend & ~push_btn);
            if (btn_accept)
                btn_type <= click ? T_PRESS : T_RELEASE;
            if (btn_drop)
                overflow <= 1'b1;

            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {push_type, pos_x, pos_y};
    end

    logic [ENT_W-1:0] head;
    assign head      = mem[rd_ptr];
    assign evt_valid = (count != '0);
    assign evt_type  = evt_valid ? head[ENT_W-1 -: 2]       : 2'd0;
    assign evt_x     = evt_valid ? head[2*POS_W-1 -: POS_W] : '0;
    assign evt_y     = evt_valid ? head[POS_W-1:0]          : '0;

endmodule

// File: tb/tb_boreal_cursor_event_fifo.sv
// Directed bench for boreal_cursor_event_fifo: latency, clamping, button queueing,
// arbitration, recentre and asynchronous reset, with hand-computed expectations.
module tb_boreal_cursor_event_fifo;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               valid;
    logic signed [23:0] ux, uy;
    logic               click;
    logic               evt_valid;
    logic               evt_ready;
    logic [1:0]         evt_type;
    logic [11:0]        evt_x, evt_y;
    logic               overflow;
    logic [2:0]         reg_addr;
    logic [15:0]        reg_din;
    logic               reg_we;

    int total = 0;
    int bad   = 0;
    logic [26:0] got, want;

    boreal_cursor_event_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .ux        (ux),
        .uy        (uy),
        .click     (click),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_type  (evt_type),
        .evt_x     (evt_x),
        .evt_y     (evt_y),
        .overflow  (overflow),
        .reg_addr  (reg_addr),
        .reg_din   (reg_din),
        .reg_we    (reg_we)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
        reg_we = 1'b1; reg_addr = a; reg_din = d;
        @(negedge clk);
        reg_we = 1'b0;
    endtask

    task automatic pulse_valid(input logic signed [23:0] x, input logic signed [23:0] y);
        valid = 1'b1; ux = x; uy = y;
        @(negedge clk);
        valid = 1'b0; ux = '0; uy = '0;
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 0; ux = '0; uy = '0; click = 0; evt_ready = 0;
        reg_we = 0; reg_addr = '0; reg_din = '0;
        tick(2);
        got = {evt_valid, evt_type, evt_x, evt_y}; want = '0;
        total++;
        if (got !== want) begin bad++; $display("FAIL reset_evt got=%h want=%h", got, want); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        rst_n = 1'b1;
    endtask

    task automatic test_first_move();
        pulse_valid(24'sd1024, 24'sd0);
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL lat_n got=%b want=0", evt_valid); end
        tick(1);
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL lat_n1 got=%b want=0", evt_valid); end
        tick(1);
        got = {evt_valid, evt_type, evt_x, evt_y}; want = {1'b1, 2'd0, 12'd1, 12'd0};
        total++;
        if (got !== want) begin bad++; $display("FAIL first_move got=%h want=%h", got, want); end
        pop_one();
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL first_pop got=%b want=0", evt_valid); end
    endtask

    task automatic test_clamp();
        reg_write(3'd0, 16'd0);
        pulse_valid(24'sd4089, 24'sd0);
        tick(2);
        got = {evt_valid, evt_type, evt_x, evt_y}; want = {1'b1, 2'd0, 12'd4090, 12'd0};
        total++;
        if (got !== want) begin bad++; $display("FAIL clamp_4090 got=%h want=%h", got, want); end
        pop_one();
        pulse_valid(24'sd100, 24'sd0);
        tick(2);
        got = {evt_valid, evt_type, evt_x, evt_y}; want = {1'b1, 2'd0, 12'd4095, 12'd0};
        total++;
        if (got !== want) begin bad++; $display("FAIL clamp_hi got=%h want=%h", got, want); end
        pop_one();
        pulse_valid(24'sd10, 24'sd0);
        tick(3);
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL clamp_nomove got=%b want=0", evt_valid); end
        pulse_valid(-24'sd100000, 24'sd100000);
        tick(2);
        got = {evt_valid, evt_type, evt_x, evt_y}; want = {1'b1, 2'd0, 12'd0, 12'd4095};
        total++;
        if (got !== want) begin bad++; $display("FAIL clip_step got=%h want=%h", got, want); end
        pop_one();
        reg_write(3'd2, 16'd500);
        tick(3);
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL ymax_lazy got=%b want=0", evt_valid); end
        pulse_valid(24'sd0, 24'sd0);
        tick(2);
        got = {evt_valid, evt_type, evt_x, evt_y}; want = {1'b1, 2'd0, 12'd0, 12'd500};
        total++;
        if (got !== want) begin bad++; $display("FAIL ymax_clamp got=%h want=%h", got, want); end
        pop_one();
        reg_write(3'd2, 16'd4095);
    endtask

    task automatic test_overflow();
        do_reset();
        reg_write(3'd3, 16'd0);
        tick(1);
        got = {evt_valid, evt_type, evt_x, evt_y}; want = {1'b1, 2'd0, 12'd2047, 12'd2047};
        total++;
        if (got !== want) begin bad++; $display("FAIL recentre_rst got=%h want=%h", got, want); end
        pop_one();
        for (int i = 0; i < 9; i++) begin
            click = ~click;
            tick(2);
        end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_9 got=%b want=0", overflow); end
        click = ~click;
        tick(2);
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_10 got=%b want=1", overflow); end
        evt_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            got = {evt_valid, evt_type, evt_x, evt_y};
            want = {1'b1, (i % 2 == 0) ? 2'd1 : 2'd2, 12'd2047, 12'd2047};
            total++;
            if (got !== want) begin bad++; $display("FAIL drain_%0d got=%h want=%h", i, got, want); end
            @(negedge clk);
        end
        evt_ready = 1'b0;
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", evt_valid); end
        reg_write(3'd4, 16'd0);
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    endtask

    task automatic test_priority();
        reg_write(3'd0, 16'd0);
        valid = 1'b1; ux = 24'sd5; uy = 24'sd0;
        @(negedge clk);
        valid = 1'b0; ux = '0; click = 1'b1;
        @(negedge clk);
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL prio_early got=%b want=0", evt_valid); end
        @(negedge clk);
        got = {evt_valid, evt_type, evt_x, evt_y}; want = {1'b1, 2'd1, 12'd2052, 12'd2047};
        total++;
        if (got !== want) begin bad++; $display("FAIL prio_press got=%h want=%h", got, want); end
        evt_ready = 1'b1;
        @(negedge clk);
        got = {evt_valid, evt_type, evt_x, evt_y}; want = {1'b1, 2'd0, 12'd2052, 12'd2047};
        total++;
        if (got !== want) begin bad++; $display("FAIL prio_move got=%h want=%h", got, want); end
        @(negedge clk);
        evt_ready = 1'b0;
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL prio_empty got=%b want=0", evt_valid); end
        click = 1'b0;
        tick(2);
        got = {evt_valid, evt_type, evt_x, evt_y}; want = {1'b1, 2'd2, 12'd2052, 12'd2047};
        total++;
        if (got !== want) begin bad++; $display("FAIL prio_release got=%h want=%h", got, want); end
        pop_one();
    endtask

    task automatic test_recentre();
        reg_write(3'd1, 16'd1919);
        reg_write(3'd2, 16'd1079);
        reg_we = 1'b1; reg_addr = 3'd3; reg_din = '0;
        valid = 1'b1; ux = 24'sd1000; uy = 24'sd1000;
        @(negedge clk);
        reg_we = 1'b0; valid = 1'b0; ux = '0; uy = '0;
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL rc_early got=%b want=0", evt_valid); end
        @(negedge clk);
        got = {evt_valid, evt_type, evt_x, evt_y}; want = {1'b1, 2'd0, 12'd959, 12'd539};
        total++;
        if (got !== want) begin bad++; $display("FAIL rc_move got=%h want=%h", got, want); end
        pop_one();
        tick(2);
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL rc_valid_dropped got=%b want=0", evt_valid); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 10; i++) begin
            click = ~click;
            tick(2);
        end
        total++;
        if ({evt_valid, overflow} !== 2'b11) begin
            bad++; $display("FAIL mr_loaded got=%b want=11", {evt_valid, overflow});
        end
        #2 rst_n = 1'b0;
        #1;
        got = {evt_valid, evt_type, evt_x, evt_y}; want = '0;
        total++;
        if (got !== want) begin bad++; $display("FAIL mr_async_evt got=%h want=%h", got, want); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL mr_async_ovf got=%b want=0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        reg_write(3'd0, 16'd0);
        pulse_valid(24'sd3, 24'sd2);
        tick(2);
        got = {evt_valid, evt_type, evt_x, evt_y}; want = {1'b1, 2'd0, 12'd3, 12'd2};
        total++;
        if (got !== want) begin bad++; $display("FAIL mr_pos got=%h want=%h", got, want); end
        pop_one();
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL mr_one_entry got=%b want=0", evt_valid); end
        reg_write(3'd3, 16'd0);
        tick(1);
        got = {evt_valid, evt_type, evt_x, evt_y}; want = {1'b1, 2'd0, 12'd2047, 12'd2047};
        total++;
        if (got !== want) begin bad++; $display("FAIL mr_max_rst got=%h want=%h", got, want); end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_first_move();
        test_clamp();
        test_overflow();
        test_priority();
        test_recentre();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
